// File: rtl/efpga_mult_pkg.sv
// Shared types and helpers for the sequential slice-based multiplier.
package efpga_mult_pkg;

    // Controller states: capture, slice accumulate, sign fix-up, hold result.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } mult_state_e;

    // Native operand width of the single hardware multiplier slice.
    localparam int unsigned SliceWDefault = 16;

    // Number of slice-wide chunks needed to cover an operand.
    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/efpga_mult_slice.sv
// Single unsigned SLICE_W x SLICE_W multiplier; kept as its own module so the
// one-slice resource stays visible to the mapper.
module efpga_mult_slice
    import efpga_mult_pkg::*;
#(
    parameter int unsigned SLICE_W = SliceWDefault
) (
    input  logic [SLICE_W-1:0]   a_i,
    input  logic [SLICE_W-1:0]   b_i,
    output logic [2*SLICE_W-1:0] p_o
);

    localparam int unsigned PW = 2 * SLICE_W;

    assign p_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/efpga_mult_seq.sv
// Multi-cycle wide multiplier built from one reused SLICE_W x SLICE_W slice.
// Operands are reduced to magnitudes, multiplied chunk by chunk into a wide
// accumulator, then the sign is restored and the result resized to Y_WIDTH.
// Optional feature: define EFPGA_MULT_SEQ_ACC_EN to add an 'acc' input that
// adds the new product to the previously delivered result.
module efpga_mult_seq
    import efpga_mult_pkg::*;
#(
    parameter int unsigned A_WIDTH  = 32,
    parameter int unsigned B_WIDTH  = 32,
    parameter bit          A_SIGNED = 1'b0,
    parameter bit          B_SIGNED = 1'b0,
    parameter int unsigned Y_WIDTH  = 64,
    parameter int unsigned SLICE_W  = SliceWDefault
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
`ifdef EFPGA_MULT_SEQ_ACC_EN
    input  logic               acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Y_WIDTH-1:0] y
);

    localparam int unsigned NA = ceil_div(A_WIDTH, SLICE_W);
    localparam int unsigned NB = ceil_div(B_WIDTH, SLICE_W);
    localparam int unsigned AW = NA * SLICE_W;
    localparam int unsigned BW = NB * SLICE_W;
    localparam int unsigned P  = AW + BW;
    localparam int unsigned IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int unsigned JW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] ILast = IW'(NA - 1);
    localparam logic [JW-1:0] JLast = JW'(NB - 1);

    mult_state_e         state_q, state_d;
    logic [AW-1:0]       a_mag_q, a_mag_d;
    logic [BW-1:0]       b_mag_q, b_mag_d;
    logic                neg_q, neg_d;
    logic [P-1:0]        acc_q, acc_d;
    logic [IW-1:0]       i_q, i_d;
    logic [JW-1:0]       j_q, j_d;
    logic [Y_WIDTH-1:0]  y_q, y_d;
`ifdef EFPGA_MULT_SEQ_ACC_EN
    logic                acc_mode_q, acc_mode_d;
`endif

    // Operand magnitudes; the most-negative value still fits unsigned.
    logic               a_neg, b_neg;
    logic [A_WIDTH-1:0] a_abs;
    logic [B_WIDTH-1:0] b_abs;

    assign a_neg = A_SIGNED && a[A_WIDTH-1];
    assign b_neg = B_SIGNED && b[B_WIDTH-1];
    assign a_abs = a_neg ? (~a + A_WIDTH'(1)) : a;
    assign b_abs = b_neg ? (~b + B_WIDTH'(1)) : b;

    // Chunk selection feeding the shared slice.
    logic [SLICE_W-1:0]   a_chunk, b_chunk;
    logic [2*SLICE_W-1:0] prod;
    logic [P-1:0]         partial;

    assign a_chunk = SLICE_W'(a_mag_q >> (SLICE_W * 32'(i_q)));
    assign b_chunk = SLICE_W'(b_mag_q >> (SLICE_W * 32'(j_q)));
    assign partial = P'(prod) << (SLICE_W * (32'(i_q) + 32'(j_q)));

    efpga_mult_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a_i (a_chunk),
        .b_i (b_chunk),
        .p_o (prod)
    );

    // Sign restore and resize of the finished magnitude product.
    logic [P-1:0]       acc_fix;
    logic [Y_WIDTH-1:0] prod_y;

    assign acc_fix = neg_q ? (~acc_q + P'(1)) : acc_q;

    if (Y_WIDTH > P) begin : g_ext
        if (A_SIGNED || B_SIGNED) begin : g_sext
            assign prod_y = {{(Y_WIDTH - P){acc_fix[P-1]}}, acc_fix};
        end else begin : g_zext
            assign prod_y = {{(Y_WIDTH - P){1'b0}}, acc_fix};
        end
    end else begin : g_trunc
        assign prod_y = Y_WIDTH'(acc_fix);
    end

    // Next-state logic: capture, accumulate partial products, fix up, hold.
    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        y_d     = y_q;
`ifdef EFPGA_MULT_SEQ_ACC_EN
        acc_mode_d = acc_mode_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_mag_d = AW'(a_abs);
                    b_mag_d = BW'(b_abs);
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
`ifdef EFPGA_MULT_SEQ_ACC_EN
                    acc_mode_d = acc;
`endif
                    state_d = StMul;
                end
            end
            StMul: begin
                acc_d = acc_q + partial;
                // j runs fastest; the last (i, j) pair hands over to FIX.
                if (j_q == JLast) begin
                    j_d = '0;
                    if (i_q == ILast) begin
                        state_d = StFix;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StFix: begin
`ifdef EFPGA_MULT_SEQ_ACC_EN
                // y_q still holds the last delivered result here.
                y_d = acc_mode_q ? (y_q + prod_y) : prod_y;
`else
                y_d = prod_y;
`endif
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            y_q     <= '0;
`ifdef EFPGA_MULT_SEQ_ACC_EN
            acc_mode_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            y_q     <= y_d;
`ifdef EFPGA_MULT_SEQ_ACC_EN
            acc_mode_q <= acc_mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = y_q;

endmodule

// File: tb/tb_efpga_mult_seq.sv
// Scoreboard bench: three multiplier configurations share one stimulus stream
// (unsigned 32x32, signed 32x32, unsigned 20x12 -> 16).
module tb_efpga_mult_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;
`ifdef EFPGA_MULT_SEQ_ACC_EN
    logic        acc_drv = 1'b0;
`endif

    logic        u_ir, u_ov, s_ir, s_ov, n_ir, n_ov;
    logic [63:0] u_y, s_y;
    logic [15:0] n_y;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] q_u[$];
    logic [63:0] q_s[$];
    logic [63:0] q_n[$];
    logic [63:0] prev_u = '0, prev_s = '0, prev_n = '0;

    always #5 clk = ~clk;

    efpga_mult_seq u_dut_u (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (u_ir),
        .a         (a_drv),
        .b         (b_drv),
`ifdef EFPGA_MULT_SEQ_ACC_EN
        .acc       (acc_drv),
`endif
        .out_valid (u_ov),
        .out_ready (out_ready),
        .y         (u_y)
    );

    efpga_mult_seq #(
        .A_SIGNED (1'b1),
        .B_SIGNED (1'b1)
    ) u_dut_s (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (s_ir),
        .a         (a_drv),
        .b         (b_drv),
`ifdef EFPGA_MULT_SEQ_ACC_EN
        .acc       (acc_drv),
`endif
        .out_valid (s_ov),
        .out_ready (out_ready),
        .y         (s_y)
    );

    efpga_mult_seq #(
        .A_WIDTH (20),
        .B_WIDTH (12),
        .Y_WIDTH (16)
    ) u_dut_n (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (n_ir),
        .a         (a_drv[19:0]),
        .b         (b_drv[11:0]),
`ifdef EFPGA_MULT_SEQ_ACC_EN
        .acc       (acc_drv),
`endif
        .out_valid (n_ov),
        .out_ready (out_ready),
        .y         (n_y)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference products.
    function automatic logic [63:0] model_u(input logic [31:0] x, input logic [31:0] z);
        return {32'b0, x} * {32'b0, z};
    endfunction

    function automatic logic [63:0] model_s(input logic [31:0] x, input logic [31:0] z);
        longint sx, sz;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        return 64'(sx * sz);
    endfunction

    function automatic logic [63:0] model_n(input logic [31:0] x, input logic [31:0] z);
        logic [31:0] p;
        p = {12'b0, x[19:0]} * {20'b0, z[11:0]};
        return {48'b0, p[15:0]};
    endfunction

    // Compare each delivered result against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn) begin
            if (u_ov && out_ready) begin
                if (q_u.size() == 0) check_eq("u_unexpected", 64'(u_ov), 64'(0));
                else check_eq("u_y", u_y, q_u.pop_front());
            end
            if (s_ov && out_ready) begin
                if (q_s.size() == 0) check_eq("s_unexpected", 64'(s_ov), 64'(0));
                else check_eq("s_y", s_y, q_s.pop_front());
            end
            if (n_ov && out_ready) begin
                if (q_n.size() == 0) check_eq("n_unexpected", 64'(n_ov), 64'(0));
                else check_eq("n_y", 64'(n_y), q_n.pop_front());
            end
        end
    end

    // Drive one operand pair for one cycle and record expected results.
    task automatic issue(input logic [31:0] x, input logic [31:0] z, input logic acc_bit);
        int budget;
        logic [63:0] e;
        budget = 0;
        @(negedge clk);
        while (!(u_ir && s_ir && n_ir) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) check_eq("issue_timeout", 64'(1), 64'(0));
        a_drv = x;
        b_drv = z;
`ifdef EFPGA_MULT_SEQ_ACC_EN
        acc_drv = acc_bit;
`endif
        in_valid = 1'b1;
        e = acc_bit ? prev_u + model_u(x, z) : model_u(x, z);
        prev_u = e;
        q_u.push_back(e);
        e = acc_bit ? prev_s + model_s(x, z) : model_s(x, z);
        prev_s = e;
        q_s.push_back(e);
        e = (acc_bit ? prev_n + model_n(x, z) : model_n(x, z)) & 64'hFFFF;
        prev_n = e;
        q_n.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_drv = $urandom;
        b_drv = $urandom;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (!(q_u.size() == 0 && q_s.size() == 0 && q_n.size() == 0 && u_ir && s_ir && n_ir)
               && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 200) check_eq("idle_timeout", 64'(1), 64'(0));
    endtask

    logic [31:0] tab_a[8] = '{32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000,
                              32'h00000001, 32'h12345678, 32'hFFFF0000, 32'h0000FFFF};
    logic [31:0] tab_b[8] = '{32'h00000003, 32'h80000000, 32'hFFFFFFFF, 32'hDEADBEEF,
                              32'h80000001, 32'h9ABCDEF0, 32'h0000FFFF, 32'hFFFF0000};

    initial begin
        int lat_u, lat_n;
        logic [63:0] hold_y;
        int budget;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(u_ir), 64'(1));
        check_eq("rst_out_valid", 64'(u_ov), 64'(0));
        check_eq("rst_y", u_y, 64'(0));
        check_eq("rst_n_in_ready", 64'(n_ir), 64'(1));
        @(negedge clk);
        resetn = 1'b1;

        // Full-scale unsigned with latency and single-cycle valid.
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        lat_u = 0;
        lat_n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (u_ov && lat_u == 0) lat_u = k;
            if (n_ov && lat_n == 0) lat_n = k;
            if (lat_u != 0) break;
        end
        check_eq("u_latency", 64'(lat_u), 64'(5));
        check_eq("n_latency", 64'(lat_n), 64'(3));
        @(posedge clk);
        #1;
        check_eq("u_valid_pulse", 64'(u_ov), 64'(0));
        check_eq("u_ready_after", 64'(u_ir), 64'(1));
        wait_idle();

        // Signed corners and assorted patterns.
        for (int k = 0; k < 8; k++) begin
            issue(tab_a[k], tab_b[k], 1'b0);
            wait_idle();
        end
        for (int k = 0; k < 4; k++) begin
            issue($urandom, $urandom, 1'b0);
            wait_idle();
        end

        // Backpressure: result held, busy, new operands ignored.
        out_ready = 1'b0;
        issue(32'h0001_2345, 32'h0000_0ABC, 1'b0);
        budget = 0;
        while (!u_ov && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_eq("bp_valid_seen", 64'(u_ov), 64'(1));
        hold_y = u_y;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_drv = $urandom;
            b_drv = $urandom;
            @(posedge clk);
            #1;
            check_eq("bp_y_stable", u_y, hold_y);
            check_eq("bp_in_ready", 64'(u_ir), 64'(0));
            check_eq("bp_out_valid", 64'(u_ov), 64'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_valid", 64'(u_ov), 64'(0));
        check_eq("bp_release_ready", 64'(u_ir), 64'(1));
        wait_idle();

        // Asynchronous reset during the second MUL cycle.
        issue(32'h0012_3456, 32'h0000_0789, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(u_ov), 64'(0));
        check_eq("arst_y", u_y, 64'(0));
        check_eq("arst_in_ready", 64'(u_ir), 64'(1));
        q_u.delete();
        q_s.delete();
        q_n.delete();
        prev_u = '0;
        prev_s = '0;
        prev_n = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        issue(32'd5, 32'd7, 1'b0);
        wait_idle();

`ifdef EFPGA_MULT_SEQ_ACC_EN
        // Accumulate onto the previously delivered result.
        issue(32'd2, 32'd3, 1'b0);
        wait_idle();
        issue(32'd4, 32'd5, 1'b1);
        wait_idle();
        issue(32'd1, 32'd1, 1'b0);
        wait_idle();
        issue(32'hFFFFFFFF, 32'd2, 1'b1);
        wait_idle();
`endif

        check_eq("queues_drained", 64'(q_u.size() + q_s.size() + q_n.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
